// File: rtl/xc_sha3_lane_decode.sv
// rtl/xc_sha3_lane_decode.sv - shifted lane index to Keccak (x,y) decoder with optional inverse pi
module xc_sha3_lane_decode #(
    parameter bit INV_PI_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_idx,
    input  logic [1:0]  in_shamt,
    input  logic        in_inv_pi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_x,
    output logic [2:0]  out_y,
    output logic [4:0]  out_idx,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  rem;
    logic [2:0]  ycnt;
    logic        inv_q;

    logic [31:0] lane;
    logic [31:0] low_mask;
    logic        req_err;
    logic        rem_ge5;
    logic [4:0]  pi_sum;
    logic [4:0]  pi_mod;
    logic [2:0]  fin_x;
    logic [2:0]  fin_y;

    assign lane     = in_idx >> in_shamt;
    assign low_mask = (32'd1 << in_shamt) - 32'd1;
    assign req_err  = (lane >= 32'd25) || ((in_idx & low_mask) != 32'd0);
    assign rem_ge5  = rem >= 5'd5;

    // rem <= 4 and ycnt <= 4 here, so the sum is at most 16 and needs at most three folds
    assign pi_sum = rem + 5'd3 * {2'b00, ycnt};
    always_comb begin
        pi_mod = pi_sum;
        if (pi_sum >= 5'd15)
            pi_mod = pi_sum - 5'd15;
        else if (pi_sum >= 5'd10)
            pi_mod = pi_sum - 5'd10;
        else if (pi_sum >= 5'd5)
            pi_mod = pi_sum - 5'd5;
    end

    always_comb begin
        fin_x = rem[2:0];
        fin_y = ycnt;
        if (inv_q) begin
            fin_x = pi_mod[2:0];
            fin_y = rem[2:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = req_err ? DONE : DIV;
            DIV:  if (!rem_ge5) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem     <= 5'd0;
            ycnt    <= 3'd0;
            inv_q   <= 1'b0;
            out_x   <= 3'd0;
            out_y   <= 3'd0;
            out_idx <= 5'd0;
            out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (req_err) begin
                            out_err <= 1'b1;
                            out_x   <= 3'd0;
                            out_y   <= 3'd0;
                            out_idx <= 5'd0;
                        end else begin
                            rem   <= lane[4:0];
                            ycnt  <= 3'd0;
                            inv_q <= in_inv_pi & INV_PI_EN;
                        end
                    end
                end
                DIV: begin
                    if (rem_ge5) begin
                        rem  <= rem - 5'd5;
                        ycnt <= ycnt + 3'd1;
                    end else begin
                        out_x   <= fin_x;
                        out_y   <= fin_y;
                        out_idx <= {2'b00, fin_x} + 5'd5 * {2'b00, fin_y};
                        out_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_sha3_lane_decode.sv
// tb/tb_xc_sha3_lane_decode.sv - self-checking bench for xc_sha3_lane_decode
module tb_xc_sha3_lane_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_idx;
    logic [1:0]  in_shamt;
    logic        in_inv_pi;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_err_a;
    logic [2:0]  out_x_a, out_y_a;
    logic [4:0]  out_idx_a;
    logic        in_ready_b, out_valid_b, out_err_b;
    logic [2:0]  out_x_b, out_y_b;
    logic [4:0]  out_idx_b;

    int n_pass  = 0;
    int n_total = 0;

    logic        exp_active = 1'b0;
    logic [2:0]  ex_a, ey_a, ex_b, ey_b;
    logic [4:0]  ei_a, ei_b;
    logic        ee_a, ee_b;

    always #5 clock = ~clock;

    xc_sha3_lane_decode #(.INV_PI_EN(1'b1)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_idx(in_idx), .in_shamt(in_shamt), .in_inv_pi(in_inv_pi),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_x(out_x_a), .out_y(out_y_a), .out_idx(out_idx_a), .out_err(out_err_a)
    );

    xc_sha3_lane_decode #(.INV_PI_EN(1'b0)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_idx(in_idx), .in_shamt(in_shamt), .in_inv_pi(in_inv_pi),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_x(out_x_b), .out_y(out_y_b), .out_idx(out_idx_b), .out_err(out_err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: plain division/modulo on the lane number; lat is edges after the accept edge
    function automatic void model(input logic [31:0] idx, input logic [1:0] sh, input logic inv,
                                  input logic en, output logic [2:0] x, output logic [2:0] y,
                                  output logic [4:0] i, output logic e, output int lat);
        int lane, div, md, fx, fy;
        lane = int'(idx >> sh);
        e = (idx >= (32'd25 << sh)) || ((idx % (32'd1 << sh)) != 0);
        if (e) begin
            x = 0; y = 0; i = 0; lat = 0;
        end else begin
            div = lane / 5;
            md  = lane % 5;
            fx = md; fy = div;
            if (inv && en) begin
                fx = (md + 3 * div) % 5;
                fy = md;
            end
            x = 3'(fx); y = 3'(fy); i = 5'(fx + 5 * fy);
            lat = div + 1;
        end
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (exp_active && out_valid_a) begin
                chk("a_x", out_x_a, ex_a);
                chk("a_y", out_y_a, ey_a);
                chk("a_idx", out_idx_a, ei_a);
                chk("a_err", out_err_a, ee_a);
                chk("b_valid", out_valid_b, 1);
                chk("b_x", out_x_b, ex_b);
                chk("b_y", out_y_b, ey_b);
                chk("b_idx", out_idx_b, ei_b);
                chk("b_err", out_err_b, ee_b);
            end else if (!exp_active) begin
                chk("idle_valid_a", out_valid_a, 0);
                chk("idle_valid_b", out_valid_b, 0);
            end
        end
    end

    task automatic run(input logic [31:0] idx, input logic [1:0] sh, input logic inv, input int hold);
        int lat_a, lat_b, n;
        model(idx, sh, inv, 1'b1, ex_a, ey_a, ei_a, ee_a, lat_a);
        model(idx, sh, inv, 1'b0, ex_b, ey_b, ei_b, ee_b, lat_b);
        n = 0;
        while (!in_ready_a && n < 20) begin @(posedge clock); #1; n++; end
        chk("ready_wait", in_ready_a, 1);
        @(negedge clock);
        in_valid = 1'b1; in_idx = idx; in_shamt = sh; in_inv_pi = inv;
        @(posedge clock); #1;
        in_valid = 1'b0;
        exp_active = 1'b1;
        n = 0;
        while (!out_valid_a && n < 10) begin @(posedge clock); #1; n++; end
        chk("latency", n, lat_a);
        repeat (hold) begin
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_out_valid", out_valid_a, 1);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        exp_active = 1'b0;
        chk("post_hs_valid", out_valid_a, 0);
        chk("post_hs_ready", in_ready_a, 1);
    endtask

    initial begin
        logic [2:0] mx, my;
        logic [4:0] mi;
        logic       me;
        int         ml;

        model(32'd23, 2'd0, 1'b0, 1'b1, mx, my, mi, me, ml);
        chk("pin23_x", mx, 3); chk("pin23_y", my, 4); chk("pin23_idx", mi, 23); chk("pin23_lat", ml, 5);
        model(32'h2C, 2'd2, 1'b0, 1'b1, mx, my, mi, me, ml);
        chk("pin11_x", mx, 1); chk("pin11_y", my, 2); chk("pin11_idx", mi, 11);
        model(32'd1, 2'd0, 1'b1, 1'b1, mx, my, mi, me, ml);
        chk("pinpi1_x", mx, 1); chk("pinpi1_y", my, 1); chk("pinpi1_idx", mi, 6);
        model(32'd10, 2'd0, 1'b1, 1'b1, mx, my, mi, me, ml);
        chk("pinpi10_x", mx, 1); chk("pinpi10_y", my, 0); chk("pinpi10_idx", mi, 1);
        model(32'd10, 2'd0, 1'b1, 1'b0, mx, my, mi, me, ml);
        chk("pinpi10_off_idx", mi, 10);
        model(32'd25, 2'd0, 1'b0, 1'b1, mx, my, mi, me, ml);
        chk("pin25_err", me, 1); chk("pin25_idx", mi, 0);
        model(32'd6, 2'd2, 1'b0, 1'b1, mx, my, mi, me, ml);
        chk("pin_mis_err", me, 1);
        model(32'h7C, 2'd2, 1'b0, 1'b1, mx, my, mi, me, ml);
        chk("pin31_err", me, 1);
        model(32'd17, 2'd0, 1'b0, 1'b1, mx, my, mi, me, ml);
        chk("pin17_x", mx, 2); chk("pin17_y", my, 3);

        reset = 1'b1; in_valid = 1'b0; in_idx = 0; in_shamt = 0; in_inv_pi = 0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", out_valid_a, 0); chk("rst_x", out_x_a, 0); chk("rst_y", out_y_a, 0);
        chk("rst_idx", out_idx_a, 0); chk("rst_err", out_err_a, 0); chk("rst_ready", in_ready_a, 1);
        @(negedge clock);
        reset = 1'b0;

        run(32'd0,  2'd0, 1'b0, 0);
        run(32'd23, 2'd0, 1'b0, 0);
        run(32'h2C, 2'd2, 1'b0, 0);
        run(32'd1,  2'd0, 1'b1, 0);
        run(32'd10, 2'd0, 1'b1, 0);
        run(32'd25, 2'd0, 1'b0, 0);
        run(32'd6,  2'd2, 1'b0, 0);
        run(32'h7C, 2'd2, 1'b0, 0);
        run(32'd17, 2'd0, 1'b0, 3);
        for (int i = 0; i < 32; i++)
            run(32'(i), 2'd0, i[0], 0);
        run(32'h3000_0000, 2'd3, 1'b0, 0);
        run(32'd96, 2'd3, 1'b1, 1);

        // Abort a long decode partway through; no result may ever appear
        @(negedge clock);
        in_valid = 1'b1; in_idx = 32'd24; in_shamt = 2'd0; in_inv_pi = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid_a, 0); chk("mid_rst_x", out_x_a, 0);
        chk("mid_rst_y", out_y_a, 0); chk("mid_rst_idx", out_idx_a, 0); chk("mid_rst_err", out_err_a, 0);
        in_valid = 1'b1; in_idx = 32'd3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("after_rst_ready", in_ready_a, 1);
        run(32'd5, 2'd0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
